// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard tracker.
// A stage entry is the subset of pipeline-register state the hazard logic cares about.
package hazard_pkg;

   localparam int REG_ADDR_W = 5;
   localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

   typedef struct packed {
      logic                  valid;
      logic [REG_ADDR_W-1:0] rd;
      logic                  regwrite;
      logic                  memread;
   } stage_entry_t;

   localparam stage_entry_t BUBBLE = '0;

endpackage

// File: rtl/hazard_stage_reg.sv
// One pipeline stage entry register with hold (freeze) and bubble-insert controls.
// Hold wins over bubble so a memory stall freezes everything, including a pending bubble.
module hazard_stage_reg
   import hazard_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   input  logic         hold,
   input  logic         load_bubble,
   input  stage_entry_t d,
   output stage_entry_t q
);

   stage_entry_t entry_d;
   stage_entry_t entry_q;

   always_comb begin
      entry_d = d;
      if (hold) begin
         entry_d = entry_q;
      end else if (load_bubble) begin
         entry_d = BUBBLE;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         entry_q <= BUBBLE;
      end else begin
         entry_q <= entry_d;
      end
   end

   assign q = entry_q;

endmodule

// File: rtl/hazard_pipe_tracker.sv
// Tracks ID/EX, EX/MEM and MEM/WB entries, detects load-use hazards and drives
// stall/bubble controls, forwarding-unit views and a saturating stall counter.
module hazard_pipe_tracker
   import hazard_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  id_valid,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic                  id_regwrite,
   input  logic                  id_memread,
   input  logic                  flush_ex,
   input  logic                  mem_stall,
   output logic                  stall_fetch,
   output logic                  bubble_idex,
   output logic [REG_ADDR_W-1:0] Rd_execute,
   output logic [REG_ADDR_W-1:0] Rd_writeback,
   output logic                  ex_regwrite,
   output logic                  wb_regwrite,
   output logic [15:0]           load_use_stalls
);

   stage_entry_t id_entry;
   stage_entry_t id_ex_q;
   stage_entry_t ex_mem_q;
   stage_entry_t mem_wb_q;
   logic         load_use;
   logic         idex_bubble;
   logic [15:0]  load_use_stalls_d;
   logic [15:0]  load_use_stalls_q;
   logic         unused_memread;

   assign id_entry = '{valid: id_valid, rd: id_rd, regwrite: id_regwrite, memread: id_memread};

   // A load writing x0 never creates a real dependency, so it is excluded.
   always_comb begin
      load_use = id_valid && id_ex_q.valid && id_ex_q.memread && (id_ex_q.rd != REG_ZERO) &&
                 ((id_ex_q.rd == id_rs1) || (id_ex_q.rd == id_rs2));
   end

   always_comb begin
      stall_fetch = 1'b0;
      bubble_idex = 1'b0;
      if (mem_stall) begin
         stall_fetch = 1'b1;
      end else if (flush_ex) begin
         bubble_idex = 1'b1;
      end else if (load_use) begin
         stall_fetch = 1'b1;
         bubble_idex = 1'b1;
      end
   end

   assign idex_bubble = flush_ex || load_use;

   hazard_stage_reg u_id_ex (
      .clk(clk), .reset(reset), .hold(mem_stall), .load_bubble(idex_bubble),
      .d(id_entry), .q(id_ex_q)
   );

   hazard_stage_reg u_ex_mem (
      .clk(clk), .reset(reset), .hold(mem_stall), .load_bubble(1'b0),
      .d(id_ex_q), .q(ex_mem_q)
   );

   hazard_stage_reg u_mem_wb (
      .clk(clk), .reset(reset), .hold(mem_stall), .load_bubble(1'b0),
      .d(ex_mem_q), .q(mem_wb_q)
   );

   // Only genuine load-use stall cycles count; a flush takes precedence over the stall.
   always_comb begin
      load_use_stalls_d = load_use_stalls_q;
      if (!mem_stall && !flush_ex && load_use && (load_use_stalls_q != 16'hFFFF)) begin
         load_use_stalls_d = load_use_stalls_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         load_use_stalls_q <= 16'd0;
      end else begin
         load_use_stalls_q <= load_use_stalls_d;
      end
   end

   assign Rd_execute      = ex_mem_q.valid ? ex_mem_q.rd : REG_ZERO;
   assign Rd_writeback    = mem_wb_q.valid ? mem_wb_q.rd : REG_ZERO;
   assign ex_regwrite     = ex_mem_q.valid && ex_mem_q.regwrite;
   assign wb_regwrite     = mem_wb_q.valid && mem_wb_q.regwrite;
   assign load_use_stalls = load_use_stalls_q;
   assign unused_memread  = ex_mem_q.memread ^ mem_wb_q.memread;

endmodule

// File: tb/tb_hazard_pipe_tracker.sv
// Self-checking bench: directed scenarios with literal expectations, then random
// traffic compared every cycle against a queue-style pipeline model.
module tb_hazard_pipe_tracker;

   logic        clk;
   logic        reset;
   logic        id_valid;
   logic [4:0]  id_rs1;
   logic [4:0]  id_rs2;
   logic [4:0]  id_rd;
   logic        id_regwrite;
   logic        id_memread;
   logic        flush_ex;
   logic        mem_stall;
   logic        stall_fetch;
   logic        bubble_idex;
   logic [4:0]  Rd_execute;
   logic [4:0]  Rd_writeback;
   logic        ex_regwrite;
   logic        wb_regwrite;
   logic [15:0] load_use_stalls;

   int checks = 0;
   int errors = 0;
   bit checkEn = 0;

   // Model pipeline: slot 0 = ID/EX, slot 1 = EX/MEM, slot 2 = MEM/WB.
   bit       mValid[3];
   bit [4:0] mRd[3];
   bit       mRw[3];
   bit       mMr[3];
   int       modelCount = 0;

   hazard_pipe_tracker dut (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
      .flush_ex(flush_ex), .mem_stall(mem_stall), .stall_fetch(stall_fetch),
      .bubble_idex(bubble_idex), .Rd_execute(Rd_execute), .Rd_writeback(Rd_writeback),
      .ex_regwrite(ex_regwrite), .wb_regwrite(wb_regwrite), .load_use_stalls(load_use_stalls)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   function automatic bit modelLoadUse();
      return id_valid && mValid[0] && mMr[0] && (mRd[0] != 0) &&
             ((mRd[0] == id_rs1) || (mRd[0] == id_rs2));
   endfunction

   // Model update on each rising edge, using inputs that are stable around the edge.
   always @(posedge clk) begin
      bit lu;
      lu = modelLoadUse();
      if (reset) begin
         for (int i = 0; i < 3; i++) begin
            mValid[i] = 0; mRd[i] = 0; mRw[i] = 0; mMr[i] = 0;
         end
         modelCount = 0;
      end else if (!mem_stall) begin
         for (int i = 2; i > 0; i--) begin
            mValid[i] = mValid[i-1]; mRd[i] = mRd[i-1]; mRw[i] = mRw[i-1]; mMr[i] = mMr[i-1];
         end
         if (flush_ex || lu) begin
            mValid[0] = 0; mRd[0] = 0; mRw[0] = 0; mMr[0] = 0;
         end else begin
            mValid[0] = id_valid; mRd[0] = id_rd; mRw[0] = id_regwrite; mMr[0] = id_memread;
         end
         if (lu && !flush_ex && modelCount < 65535) modelCount++;
      end
   end

   // Compare process: every falling edge the outputs must match the model.
   always @(negedge clk) begin
      int expSf;
      int expBub;
      if (checkEn) begin
         expSf  = mem_stall ? 1 : (flush_ex ? 0 : (modelLoadUse() ? 1 : 0));
         expBub = mem_stall ? 0 : ((flush_ex || modelLoadUse()) ? 1 : 0);
         checkOutput("stall_fetch", stall_fetch, expSf);
         checkOutput("bubble_idex", bubble_idex, expBub);
         checkOutput("Rd_execute", Rd_execute, mValid[1] ? int'(mRd[1]) : 0);
         checkOutput("Rd_writeback", Rd_writeback, mValid[2] ? int'(mRd[2]) : 0);
         checkOutput("ex_regwrite", ex_regwrite, int'(mValid[1] && mRw[1]));
         checkOutput("wb_regwrite", wb_regwrite, int'(mValid[2] && mRw[2]));
         checkOutput("load_use_stalls", load_use_stalls, modelCount);
      end
   end

   task automatic applyStimulus(input bit v, input int rs1, input int rs2, input int rd,
                                input bit rw, input bit mr, input bit fl, input bit ms);
      id_valid = v; id_rs1 = 5'(rs1); id_rs2 = 5'(rs2); id_rd = 5'(rd);
      id_regwrite = rw; id_memread = mr; flush_ex = fl; mem_stall = ms;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      reset = 1;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      reset = 0;
   endtask

   initial begin
      reset = 0;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      doReset();
      checkEn = 1;
      checkOutput("reset_stall_fetch", stall_fetch, 0);
      checkOutput("reset_Rd_execute", Rd_execute, 0);
      checkOutput("reset_counter", load_use_stalls, 0);

      // lw x5 ; add x6,x5,x7
      applyStimulus(1, 0, 0, 5, 1, 1, 0, 0);
      tick();
      applyStimulus(1, 5, 7, 6, 1, 0, 0, 0);
      #1;
      checkOutput("lu_stall_fetch", stall_fetch, 1);
      checkOutput("lu_bubble", bubble_idex, 1);
      tick();
      checkOutput("lu_Rd_execute", Rd_execute, 5);
      checkOutput("lu_ex_regwrite", ex_regwrite, 1);
      checkOutput("lu_counter", load_use_stalls, 1);
      checkOutput("lu_released", stall_fetch, 0);
      tick();

      // lw x0 ; add using x0
      doReset();
      applyStimulus(1, 0, 0, 0, 1, 1, 0, 0);
      tick();
      applyStimulus(1, 0, 0, 6, 1, 0, 0, 0);
      #1;
      checkOutput("x0_no_stall", stall_fetch, 0);
      tick();
      checkOutput("x0_counter", load_use_stalls, 0);

      // add x3 in cycle 0 with no stalls
      doReset();
      applyStimulus(1, 1, 2, 3, 1, 0, 0, 0);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      checkOutput("lat_Rd_execute", Rd_execute, 3);
      checkOutput("lat_ex_regwrite", ex_regwrite, 1);
      tick();
      checkOutput("lat_Rd_writeback", Rd_writeback, 3);
      checkOutput("lat_wb_regwrite", wb_regwrite, 1);

      // load-use together with flush
      doReset();
      applyStimulus(1, 0, 0, 5, 1, 1, 0, 0);
      tick();
      applyStimulus(1, 5, 7, 6, 1, 0, 1, 0);
      #1;
      checkOutput("flush_stall_fetch", stall_fetch, 0);
      checkOutput("flush_bubble", bubble_idex, 1);
      tick();
      checkOutput("flush_counter", load_use_stalls, 0);
      checkOutput("flush_Rd_execute", Rd_execute, 5);

      // mem_stall held three cycles with x9 in EX/MEM
      doReset();
      applyStimulus(1, 0, 0, 9, 1, 0, 0, 0);
      tick();
      applyStimulus(1, 1, 1, 4, 1, 0, 0, 0);
      tick();
      checkOutput("ms_pre_Rd_execute", Rd_execute, 9);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1, 1, 1, 4, 1, 0, 0, 1);
         #1;
         checkOutput("ms_stall_fetch", stall_fetch, 1);
         checkOutput("ms_bubble", bubble_idex, 0);
         tick();
         checkOutput("ms_Rd_execute", Rd_execute, 9);
      end
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      tick();

      // saturation: preload near the top, then two further stalls
      force dut.load_use_stalls_q = 16'hFFFE;
      modelCount = 65534;
      #1;
      release dut.load_use_stalls_q;
      for (int i = 0; i < 2; i++) begin
         applyStimulus(1, 0, 0, 5, 1, 1, 0, 0);
         tick();
         applyStimulus(1, 7, 5, 6, 1, 0, 0, 0);
         tick();
         checkOutput("sat_counter", load_use_stalls, 16'hFFFF);
      end
      reset = 1;
      applyStimulus(1, 5, 5, 5, 1, 1, 1, 1);
      tick();
      reset = 0;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      checkOutput("post_counter", load_use_stalls, 0);
      checkOutput("post_Rd_execute", Rd_execute, 0);
      checkOutput("post_Rd_writeback", Rd_writeback, 0);
      checkOutput("post_ex_regwrite", ex_regwrite, 0);
      checkOutput("post_wb_regwrite", wb_regwrite, 0);
      checkOutput("post_stall_fetch", stall_fetch, 0);
      checkOutput("post_bubble", bubble_idex, 0);

      // random traffic over a small register set to provoke collisions
      for (int n = 0; n < 3000; n++) begin
         reset = ($urandom_range(0, 99) == 0);
         applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
                       $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1),
                       $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
         tick();
      end

      checkEn = 0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/hazard_pipe_tracker.md
HAZARD_PIPE_TRACKER -- requirements
Module: hazard_pipe_tracker

Interface
REQ-001 SHALL have port: clk  input  1  single pipeline clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: id_valid  input  1  ID stage holds a real instruction.
REQ-004 SHALL have ports: id_rs1, id_rs2  input  5  source registers of the ID instruction.
REQ-005 SHALL have port: id_rd  input  5  destination register of the ID instruction.
REQ-006 SHALL have ports: id_regwrite, id_memread  input  1  ID instruction writes a register / is a load.
REQ-007 SHALL have port: flush_ex  input  1  branch/jump taken in EX; kills the ID instruction.
REQ-008 SHALL have port: mem_stall  input  1  data memory not ready; freezes the pipeline.
REQ-009 SHALL have port: stall_fetch  output  1  hold PC and IF/ID.
REQ-010 SHALL have port: bubble_idex  output  1  a bubble is being inserted into ID/EX this cycle.
REQ-011 SHALL have ports: Rd_execute, Rd_writeback  output  5  EX/MEM.rd and MEM/WB.rd feeding the forwarding unit.
REQ-012 SHALL have ports: ex_regwrite, wb_regwrite  output  1  EX/MEM and MEM/WB regwrite, each masked by stage valid.
REQ-013 SHALL have port: load_use_stalls  output  16  saturating count of load-use stall cycles.

Function
REQ-014 SHALL keep three stage entries (ID/EX, EX/MEM, MEM/WB), each holding {valid, rd, regwrite, memread}.
REQ-015 SHALL compute load_use combinationally: id_valid, ID/EX.valid, ID/EX.memread, ID/EX.rd!=0, and ID/EX.rd equal to id_rs1 or id_rs2.
REQ-016 SHALL give mem_stall highest priority: all stage entries hold, stall_fetch=1, bubble_idex=0, counter holds.
REQ-017 SHALL, when flush_ex=1 and mem_stall=0, load a bubble into ID/EX and advance EX/MEM and MEM/WB.
REQ-018 SHALL, under flush_ex=1, drive stall_fetch=0 and bubble_idex=1, with no counter increment even if load_use=1.
REQ-019 SHALL, when load_use=1 with mem_stall=0 and flush_ex=0, drive stall_fetch=1 and bubble_idex=1.
REQ-020 SHALL, in that load-use case, load a bubble into ID/EX, advance EX/MEM and MEM/WB, and increment the counter.
REQ-021 SHALL otherwise load ID/EX from the id_* inputs and shift ID/EX to EX/MEM and EX/MEM to MEM/WB, with stall_fetch=0 and bubble_idex=0.
REQ-022 SHALL define a bubble as valid=0, rd=0, regwrite=0, memread=0.
REQ-023 SHALL drive Rd_execute/Rd_writeback to 0 when the corresponding stage is invalid.
REQ-024 SHALL pass rd=0 through unmasked when the stage is valid; the forwarding unit rejects x0.
REQ-025 SHALL meet latency: an instruction in ID at cycle n, with no stall, appears on Rd_execute/ex_regwrite at n+2 and on Rd_writeback/wb_regwrite at n+3.
REQ-026 SHALL resolve a load followed by a dependent instruction with exactly one stall cycle, after which the load is in EX/MEM.
REQ-027 SHALL saturate load_use_stalls at 16'hFFFF with no wrap.

Reset
REQ-028 SHALL, on reset=1 at a clock edge, clear all stage entries to bubbles and load_use_stalls to 0.
REQ-029 SHALL, after reset, drive all outputs 0, since no stage entry is a load.
REQ-030 SHALL let reset override mem_stall, flush_ex and load_use when they are asserted in the same cycle.

Structure
REQ-031 SHALL place stage_entry_t (valid, rd[4:0], regwrite, memread), REG_ADDR_W=5, REG_ZERO=5'd0 and BUBBLE constant in shared package hazard_pkg.
REQ-032 SHALL implement each stage as a sub-module instance hazard_stage_reg with ports clk, reset, hold, load_bubble, d, q.

Verification
REQ-033 SHALL cover: lw x5 then add x6,x5,x7 -> one cycle with stall_fetch=1 and bubble_idex=1; Rd_execute=5 and ex_regwrite=1 next cycle; counter=1.
REQ-034 SHALL cover: lw x0 then add using x0 -> no stall; counter stays 0.
REQ-035 SHALL cover: add x3 with id_valid=1 in cycle 0, no stalls -> Rd_execute=3 in cycle 2 and Rd_writeback=3 in cycle 3.
REQ-036 SHALL cover: load-use and flush_ex together -> stall_fetch=0, bubble_idex=1, counter unchanged.
REQ-037 SHALL cover: mem_stall held 3 cycles with Rd_execute=9 -> Rd_execute stays 9 and stall_fetch=1 for all 3 cycles.
REQ-038 SHALL cover: counter preloaded to 16'hFFFF by 65535 load-use stalls, then a further stall -> stays 16'hFFFF; reset then -> 0 and all outputs 0.
